// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : fb_pixel_writer
// Purpose  : Buffered single-pixel framebuffer writer for the external 16-bit
//            SRAM; yields the SRAM to the display line fetcher on request.
// Revision : 1.0 - initial release
// ============================================================================
module fb_pixel_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LINE_WORDS = 800,
    parameter int MAX_X      = 800,
    parameter int MAX_Y      = 600
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [15:0] pix_data,
    input  logic [1:0]  pix_be,
    input  logic        rd_req,
    output logic        rd_gnt,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_dout,
    output logic        ram_ce,
    output logic        ram_oe,
    output logic        ram_we,
    output logic        ram_lb,
    output logic        ram_hb,
    output logic [7:0]  drop_count
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 18 + 16 + 2;

    localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_full   = CNT_W'(FIFO_DEPTH);
    localparam logic [17:0]      c_line_words = 18'(LINE_WORDS);
    localparam logic [7:0]       c_drop_max   = 8'hFF;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_strobe  = 3'd2;
    localparam logic [2:0] c_st_recover = 3'd3;
    localparam logic [2:0] c_st_grant   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic               w_pop;

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_be;

    logic               w_accept;
    logic               w_in_range;
    logic               w_push;
    logic               w_empty;
    logic               w_busy;
    logic [17:0]        w_addr;
    logic [ENTRY_W-1:0] w_head;

    // Modular 18-bit arithmetic yields exactly the truncated linear address.
    assign w_addr     = 18'(pix_y) * c_line_words + 18'(pix_x);
    assign w_in_range = (32'(pix_x) < MAX_X) && (32'(pix_y) < MAX_Y);
    assign pix_ready  = (r_count != c_cnt_full);
    assign w_accept   = pix_valid & pix_ready;
    assign w_push     = w_accept & w_in_range;
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk100) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_addr, pix_data, pix_be};
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (w_accept && !w_in_range && (drop_count != c_drop_max)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The fetcher wins only at cycle boundaries; SETUP/STROBE always finish.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            c_st_idle, c_st_recover: begin
                if (rd_req) begin
                    w_next_state = c_st_grant;
                end else if (!w_empty) begin
                    w_next_state = c_st_setup;
                    w_pop        = 1'b1;
                end else begin
                    w_next_state = c_st_idle;
                end
            end
            c_st_setup:  w_next_state = c_st_strobe;
            c_st_strobe: w_next_state = c_st_recover;
            c_st_grant: begin
                if (!rd_req) begin
                    w_next_state = c_st_idle;
                end
            end
            default:     w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            ram_dout <= '0;
            r_be     <= '0;
        end else if (w_pop) begin
            ram_addr <= w_head[ENTRY_W-1 -: 18];
            ram_dout <= w_head[17:2];
            r_be     <= w_head[1:0];
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign w_busy = (r_state == c_st_setup) || (r_state == c_st_strobe) ||
                    (r_state == c_st_recover);
    assign ram_ce = w_busy;
    assign ram_we = (r_state == c_st_strobe);
    assign ram_oe = 1'b0;
    assign ram_lb = w_busy & r_be[0];
    assign ram_hb = w_busy & r_be[1];
    assign rd_gnt = (r_state == c_st_grant);

endmodule
`default_nettype wire
